// File: rtl/norm_shift_ctrl.sv
// Mantissa normalisation sequencer that drives an external universal shift register.
// Optional sticky-bit tracking on the carry downshift is enabled by defining NORM_STICKY_EN.
module norm_shift_ctrl #(
  parameter int unsigned C_NUM_BITS = 24,
  parameter int unsigned C_EXP_BITS = 8,
  localparam int unsigned C_SHAMT_BITS = $clog2(C_NUM_BITS) + 1
) (
  input  logic                    i_ck,
  input  logic                    i_rst,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [C_NUM_BITS-1:0]   i_mant,
  input  logic [C_EXP_BITS-1:0]   i_exp,
  input  logic                    i_carry,
  output logic                    o_sr_s0,
  output logic                    o_sr_s1,
  output logic                    o_sr_sri,
  output logic                    o_sr_sli,
  output logic [C_NUM_BITS-1:0]   o_sr_d,
  input  logic [C_NUM_BITS-1:0]   i_sr_q,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [C_EXP_BITS-1:0]   o_exp_out,
  output logic [C_SHAMT_BITS-1:0] o_shamt,
  output logic                    o_zero,
  output logic                    o_underflow,
  output logic                    o_overflow,
  output logic                    o_sticky
);

  localparam logic [C_EXP_BITS-1:0]   C_EXP_ONE   = C_EXP_BITS'(1);
  localparam logic [C_EXP_BITS-1:0]   C_EXP_MAX   = '1;
  localparam logic [C_SHAMT_BITS-1:0] C_SHAMT_ONE = C_SHAMT_BITS'(1);

  typedef enum logic [1:0] {StIdle, StNorm, StDone} state_e;

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [C_EXP_BITS-1:0]   r_exp;
  logic [C_SHAMT_BITS-1:0] r_shamt;
  logic                    r_carry;
  logic                    r_zero;
  logic                    r_underflow;
  logic                    r_overflow;

  logic w_accept;
  logic w_q_zero;
  logic w_in_norm;
  logic w_do_down;
  logic w_do_zero;
  logic w_do_msb;
  logic w_do_uflow;
  logic w_do_up;

  // Accept is blocked while reset is held so the register is never loaded during reset.
  assign w_accept  = (r_state == StIdle) && i_in_valid && !i_rst;
  assign w_q_zero  = (i_sr_q == '0);
  assign w_in_norm = (r_state == StNorm);

  // NORM decisions in priority order; exactly one is active per NORM cycle.
  assign w_do_down  = w_in_norm && r_carry;
  assign w_do_zero  = w_in_norm && !r_carry && w_q_zero;
  assign w_do_msb   = w_in_norm && !r_carry && !w_q_zero && i_sr_q[C_NUM_BITS-1];
  assign w_do_uflow = w_in_norm && !r_carry && !w_q_zero && !i_sr_q[C_NUM_BITS-1]
                      && (r_exp == '0);
  assign w_do_up    = w_in_norm && !r_carry && !w_q_zero && !i_sr_q[C_NUM_BITS-1]
                      && (r_exp != '0);

  // State register
  always_ff @(posedge i_ck or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: begin
        if (w_accept) w_state_nxt = StNorm;
      end
      StNorm: begin
        if (w_do_zero || w_do_msb || w_do_uflow) w_state_nxt = StDone;
      end
      StDone: begin
        if (i_out_ready) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Exponent, shift count and flags; all hold outside NORM until the next accept.
  always_ff @(posedge i_ck or posedge i_rst) begin
    if (i_rst) begin
      r_exp       <= '0;
      r_shamt     <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (w_accept) begin
      r_exp       <= i_exp;
      r_shamt     <= '0;
      r_carry     <= i_carry;
      r_zero      <= 1'b0;
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_do_down) begin
        r_carry <= 1'b0;
        if (r_exp == C_EXP_MAX) begin
          r_overflow <= 1'b1;
        end else begin
          r_exp <= r_exp + C_EXP_ONE;
        end
      end
      if (w_do_zero) begin
        r_zero <= 1'b1;
        r_exp  <= '0;
      end
      if (w_do_uflow) begin
        r_underflow <= 1'b1;
      end
      if (w_do_up) begin
        r_exp   <= r_exp - C_EXP_ONE;
        r_shamt <= r_shamt + C_SHAMT_ONE;
      end
    end
  end

`ifdef NORM_STICKY_EN
  logic r_sticky;

  // The bit leaving Q[0] during the carry downshift is lost.
  always_ff @(posedge i_ck or posedge i_rst) begin
    if (i_rst) begin
      r_sticky <= 1'b0;
    end else if (w_accept) begin
      r_sticky <= 1'b0;
    end else if (w_do_down && i_sr_q[0]) begin
      r_sticky <= 1'b1;
    end
  end

  assign o_sticky = r_sticky;
`else
  assign o_sticky = 1'b0;
`endif

  // Output logic; mode encoding (S0,S1): 00 hold, 01 down, 10 up, 11 load.
  always_comb begin
    o_sr_s0     = 1'b0;
    o_sr_s1     = 1'b0;
    o_sr_sli    = 1'b0;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    case (r_state)
      StIdle: begin
        o_in_ready = !i_rst;
        if (w_accept) begin
          o_sr_s0 = 1'b1;
          o_sr_s1 = 1'b1;
        end
      end
      StNorm: begin
        if (w_do_down) begin
          o_sr_s1  = 1'b1;
          o_sr_sli = 1'b1;
        end else if (w_do_up) begin
          o_sr_s0 = 1'b1;
        end
      end
      StDone: begin
        o_out_valid = 1'b1;
      end
      default: begin
        o_out_valid = 1'b0;
      end
    endcase
  end

  assign o_sr_sri    = 1'b0;
  assign o_sr_d      = i_mant;
  assign o_exp_out   = r_exp;
  assign o_shamt     = r_shamt;
  assign o_zero      = r_zero;
  assign o_underflow = r_underflow;
  assign o_overflow  = r_overflow;

endmodule

// File: doc/norm_shift_ctrl.md
# norm_shift_ctrl

Sequencer that normalises a floating-point mantissa held in the downstream universal shift register. It accepts a mantissa, exponent and carry over a valid/ready handshake and parallel-loads the register. It then drives the register's mode selects until the leading one reaches bit C_NUM_BITS-1, adjusting the exponent, and presents the result over a second handshake. It sits between the mantissa adder/multiplier and the 24-bit shift register (default sizing).

## Interface
- C_NUM_BITS, 24, mantissa width; must match the shift register
- C_EXP_BITS, 8, unsigned biased exponent width
- CK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset; top level ties the register's RN to ~RST
- IN_VALID  in  1  upstream operand valid
- IN_READY  out  1  block can accept an operand
- MANT  in  C_NUM_BITS  unnormalised mantissa
- EXP  in  C_EXP_BITS  exponent of MANT
- CARRY  in  1  adder carry-out; implicit bit above MANT[C_NUM_BITS-1]
- SR_S0, SR_S1  out  1  shift register mode selects
- SR_SRI  out  1  serial input entering Q[0] on upshift
- SR_SLI  out  1  serial input entering Q[C_NUM_BITS-1] on downshift
- SR_D  out  C_NUM_BITS  parallel-load data
- SR_Q  in  C_NUM_BITS  shift register contents
- OUT_VALID  out  1  result valid; SR_Q holds the normalised mantissa
- OUT_READY  in  1  downstream accepts the result
- EXP_OUT  out  C_EXP_BITS  adjusted exponent
- SHAMT  out  $clog2(C_NUM_BITS)+1  number of upshifts performed
- ZERO, UNDERFLOW, OVERFLOW, STICKY  out  1  result flags

## Operation
- Mode encoding (S0,S1):
  - 00: hold
  - 01: downshift, Q[i]<=Q[i+1], SLI into MSB
  - 10: upshift, Q[i]<=Q[i-1], SRI into Q[0]
  - 11: load
- States: IDLE, NORM, DONE.
- **IDLE**
  - IN_READY=1; selects=00.
  - On IN_VALID: selects=11 and SR_D=MANT in the same cycle.
  - On that edge: capture EXP and CARRY, clear SHAMT and flags, go to NORM.
- **NORM**: one decision per cycle, evaluated in priority order:
  1. Carry flag set: selects=01, SLI=1. EXP_OUT+1, saturating at all-ones. If EXP_OUT was already all-ones, set OVERFLOW. Clear the carry flag; stay in NORM.
  2. SR_Q==0: ZERO=1, EXP_OUT=0, selects=00, go to DONE.
  3. SR_Q[MSB]==1: selects=00, go to DONE.
  4. EXP_OUT==0: UNDERFLOW=1, selects=00, go to DONE (denormal result left in place).
  5. Otherwise: selects=10, SRI=0, EXP_OUT-1, SHAMT+1; stay in NORM.
- **DONE**
  - OUT_VALID=1; selects=00.
  - Outputs stay stable while OUT_READY=0.
  - On OUT_READY: go to IDLE. Flags and EXP_OUT hold until the next accept.
- SR_SRI is always 0. SR_SLI=1 only during the carry downshift, otherwise 0. SR_D=MANT at all times.
- Exponent arithmetic is unsigned modulo-free: decrement is never issued at 0, and increment saturates.

## Timing
- Accept edge = edge where IN_VALID && IN_READY.
- Latency from the accept edge to OUT_VALID high:
  - k+1 edges, where k = leading-zero count of MANT.
  - 2 edges when CARRY=1 (downshift, then decision).
  - 1 edge when MANT=0 and CARRY=0.
- Leading-one search is bounded: at most C_NUM_BITS-1 upshifts.
- No new operand is accepted until the DONE handshake completes, so throughput is one operand per latency+1 cycles minimum.
- **Reset**, asynchronous and at any time, including mid-NORM:
  - state=IDLE.
  - IN_READY=0 while RST is high, 1 after release.
  - OUT_VALID=0.
  - SR_S0=SR_S1=0, SR_SRI=SR_SLI=0.
  - EXP_OUT=0, SHAMT=0, all flags 0.
  - The register clears via RN.
- OUT_READY asserted outside DONE is ignored.

## Configuration
- NORM_STICKY_EN defined: STICKY is set when SR_Q[0]==1 during the carry downshift cycle (a bit is lost). It is cleared on accept.
- NORM_STICKY_EN undefined: STICKY is tied to 0 and no sticky logic is instantiated.

## Test plan
- MANT=0x400000, EXP=10, CARRY=0 -> one upshift; OUT_VALID 2 edges after accept; SR_Q=0x800000, EXP_OUT=9, SHAMT=1, flags 0.
- MANT=0x000001, EXP=100 -> 23 upshifts; SR_Q=0x800000, EXP_OUT=77, SHAMT=23, OUT_VALID at edge 24.
- CARRY=1, MANT=0x000003, EXP=5 -> one downshift; SR_Q=0x800001, EXP_OUT=6. STICKY=1 with NORM_STICKY_EN, 0 without. CARRY=1, EXP=255 -> OVERFLOW=1, EXP_OUT=255.
- MANT=0, EXP=40 -> ZERO=1, EXP_OUT=0, OUT_VALID 1 edge after accept. MANT=0x000100, EXP=3 -> 3 upshifts, SR_Q=0x000800, EXP_OUT=0, UNDERFLOW=1.
- Hold OUT_READY=0 for 10 cycles in DONE -> OUT_VALID, SR_Q, EXP_OUT and IN_READY=0 stay stable. Raising OUT_READY returns to IDLE the next edge.
- Assert RST for 1 cycle midway through the 0x000001 case -> all outputs return to reset values immediately. A new operand after release normalises correctly.
